// File: rtl/osci_trig_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : osci_trig_capture_if
// Description : Sample stream, trigger configuration, CPU read port and
//               status bundle for the oscilloscope trigger/capture block.
// Revision    : 1.0 - initial release
// ============================================================================
interface osci_trig_capture_if #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10
);
  logic                  sample_valid;
  logic [DATA_W-1:0]     sample_data;
  logic                  arm;
  logic [DATA_W-1:0]     trig_level;
  logic                  trig_rising;
  logic [DEPTH_LOG2-1:0] post_count;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DATA_W-1:0]     rd_data;
  logic [DEPTH_LOG2-1:0] start_addr;
  logic                  busy;
  logic                  capture_done;
  logic [1:0]            state;

  // Sample source / register bank side
  modport master (
    output sample_valid, sample_data, arm, trig_level, trig_rising,
           post_count, rd_addr,
    input  rd_data, start_addr, busy, capture_done, state
  );

  // Capture engine side
  modport slave (
    input  sample_valid, sample_data, arm, trig_level, trig_rising,
           post_count, rd_addr,
    output rd_data, start_addr, busy, capture_done, state
  );
endinterface
`default_nettype wire

// File: rtl/osci_trig_capture.sv
`default_nettype none
// ============================================================================
// Module      : osci_trig_capture
// Description : Circular-buffer oscilloscope capture with level trigger
//               (rising/falling), programmable post-trigger count and a
//               registered CPU read port relative to the oldest sample.
//               Optional macro OSCI_FORCE_TRIG_EN adds a force_trig input.
// Revision    : 1.0 - initial release
// ============================================================================
module osci_trig_capture #(
  parameter int DATA_W     = 12,
  parameter int DEPTH_LOG2 = 10
) (
  input  wire logic          ACLK,
  input  wire logic          ARESETN,
  osci_trig_capture_if.slave bus
`ifdef OSCI_FORCE_TRIG_EN
  ,
  input  wire logic          force_trig
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ARMED = 2'd1;
  localparam logic [1:0] C_POST  = 2'd2;
  localparam logic [1:0] C_DONE  = 2'd3;

  localparam logic [DEPTH_LOG2-1:0] C_REM_ONE = DEPTH_LOG2'(1);

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_next;
  logic [DEPTH_LOG2-1:0] r_start_addr;
  logic [DEPTH_LOG2-1:0] r_remaining;
  logic [DATA_W-1:0]     r_prev;
  logic                  r_prev_valid;
  logic [DATA_W-1:0]     r_level;
  logic                  r_rising;
  logic [DEPTH_LOG2-1:0] r_post;
  logic                  r_done;
  logic                  w_level_hit;
  logic                  w_force;
  logic                  w_trig;
  logic                  w_write;
  logic                  w_busy;
  logic                  w_enter_done;
  logic [DEPTH_LOG2-1:0] w_rd_phys;
  logic [DATA_W-1:0]     r_rd_data;
  logic [DATA_W-1:0]     r_mem [DEPTH];

`ifdef OSCI_FORCE_TRIG_EN
  logic r_force_pend;

  // A force request in ARMED is held until the next valid sample consumes it
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_force_pend <= 1'b0;
    end else if (bus.arm || w_trig) begin
      r_force_pend <= 1'b0;
    end else if (r_state == C_ARMED && force_trig) begin
      r_force_pend <= 1'b1;
    end
  end

  assign w_force = r_force_pend || force_trig;
`else
  assign w_force = 1'b0;
`endif

  // Trigger detection: the first sample after arm only primes r_prev;
  // a concurrent arm pre-empts any trigger
  always_comb begin
    w_level_hit = 1'b0;
    if (r_prev_valid) begin
      if (r_rising)
        w_level_hit = (r_prev < r_level) && (bus.sample_data >= r_level);
      else
        w_level_hit = (r_prev >= r_level) && (bus.sample_data < r_level);
    end
    w_trig = (r_state == C_ARMED) && bus.sample_valid && !bus.arm &&
             (w_level_hit || w_force);
  end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= C_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next-state logic; arm overrides every other transition
  always_comb begin
    w_next_state = r_state;
    if (bus.arm) begin
      w_next_state = C_ARMED;
    end else begin
      case (r_state)
        C_ARMED: if (w_trig) w_next_state = C_POST;
        C_POST:  if (r_remaining == '0 ||
                     (bus.sample_valid && r_remaining == C_REM_ONE))
                   w_next_state = C_DONE;
        default: w_next_state = r_state;
      endcase
    end
  end

  // FSM outputs and write decode; POST with nothing remaining stores no more
  always_comb begin
    w_busy        = (r_state == C_ARMED) || (r_state == C_POST);
    w_write       = bus.sample_valid && !bus.arm &&
                    ((r_state == C_ARMED) ||
                     (r_state == C_POST && r_remaining != '0));
    w_wr_ptr_next = w_write ? r_wr_ptr + C_REM_ONE : r_wr_ptr;
    w_enter_done  = (w_next_state == C_DONE) && (r_state != C_DONE);
  end

  // Configuration latch, previous-sample tracking, pointers and done pulse
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_level      <= '0;
      r_rising     <= 1'b0;
      r_post       <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_wr_ptr     <= '0;
      r_remaining  <= '0;
      r_start_addr <= '0;
      r_done       <= 1'b0;
    end else begin
      if (bus.arm) begin
        r_level      <= bus.trig_level;
        r_rising     <= bus.trig_rising;
        r_post       <= bus.post_count;
        r_prev_valid <= 1'b0;
      end else if (r_state == C_ARMED && bus.sample_valid) begin
        r_prev       <= bus.sample_data;
        r_prev_valid <= 1'b1;
      end
      r_wr_ptr <= w_wr_ptr_next;
      if (w_trig)
        r_remaining <= r_post;
      else if (r_state == C_POST && w_write)
        r_remaining <= r_remaining - C_REM_ONE;
      if (w_enter_done)
        r_start_addr <= w_wr_ptr_next;
      r_done <= w_enter_done;
    end
  end

  assign w_rd_phys = r_start_addr + bus.rd_addr;

  // Capture RAM: one write port, registered read relative to the oldest sample
  always_ff @(posedge ACLK) begin
    if (w_write) r_mem[r_wr_ptr] <= bus.sample_data;
    r_rd_data <= r_mem[w_rd_phys];
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.start_addr   = r_start_addr;
  assign bus.busy         = w_busy;
  assign bus.capture_done = r_done;
  assign bus.state        = r_state;

endmodule
`default_nettype wire

// File: tb/tb_osci_trig_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_osci_trig_capture
// Description : Directed self-checking bench for osci_trig_capture with a
//               buffer model and a read-data scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_osci_trig_capture;
  localparam int DW    = 12;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  osci_trig_capture_if #(.DATA_W(DW), .DEPTH_LOG2(AW)) bus ();
`ifdef OSCI_FORCE_TRIG_EN
  logic force_trig;
`endif

  osci_trig_capture #(.DATA_W(DW), .DEPTH_LOG2(AW)) dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .bus        (bus)
`ifdef OSCI_FORCE_TRIG_EN
    ,
    .force_trig (force_trig)
`endif
  );

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;
  logic [DW-1:0] mem_m [DEPTH];
  int m_wr = 0;
  logic [DW-1:0] exp_q [$];

  // Count every cycle capture_done is seen high
  always @(negedge clk) if (bus.capture_done === 1'b1) done_cnt++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] v, input bit wr);
    bus.sample_valid = 1'b1;
    bus.sample_data  = v;
    if (wr) begin
      mem_m[m_wr] = v;
      m_wr = (m_wr + 1) % DEPTH;
    end
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic do_arm(input logic [DW-1:0] lvl, input logic rising, input logic [AW-1:0] post);
    bus.trig_level  = lvl;
    bus.trig_rising = rising;
    bus.post_count  = post;
    bus.arm         = 1'b1;
    tick();
    bus.arm         = 1'b0;
  endtask

  // Expected word is pushed when the address is driven, popped after the edge
  task automatic rd_check(input string tag, input int addr);
    bus.rd_addr = addr[AW-1:0];
    exp_q.push_back(mem_m[(m_wr + addr) % DEPTH]);
    tick();
    check(tag, bus.rd_data, exp_q.pop_front());
  endtask

  task automatic wait_done(input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (bus.capture_done === 1'b1) got = 1'b1;
      else tick();
    end
    check(tag, got, 1);
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.arm          = 1'b0;
    bus.trig_level   = '0;
    bus.trig_rising  = 1'b0;
    bus.post_count   = '0;
    bus.rd_addr      = '0;
`ifdef OSCI_FORCE_TRIG_EN
    force_trig       = 1'b0;
`endif
    tick(); tick();
    check("rst_state", bus.state, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.capture_done, 0);
    check("rst_start", bus.start_addr, 0);
    rst_n = 1'b1;
    tick();

    // Rising trigger at 0x800, four post samples
    do_arm(12'h800, 1'b1, 10'd4);
    check("a_state_armed", bus.state, 1);
    check("a_busy", bus.busy, 1);
    send(12'h700, 1'b1);
    check("a_no_first_trig", bus.state, 1);
    send(12'h900, 1'b1);
    check("a_state_post", bus.state, 2);
    send(12'hA01, 1'b1);
    send(12'hA02, 1'b1);
    send(12'hA03, 1'b1);
    check("a_no_early_done", bus.capture_done, 0);
    send(12'hA04, 1'b1);
    check("a_done_pulse", bus.capture_done, 1);
    check("a_state_done", bus.state, 3);
    check("a_start", bus.start_addr, 6);
    tick();
    check("a_done_one_cycle", bus.capture_done, 0);
    check("a_busy_done", bus.busy, 0);
    send(12'hBBB, 1'b0);
    rd_check("a_rd_oldest", DEPTH - 6);
    rd_check("a_rd_trig", DEPTH - 5);
    rd_check("a_rd_last", DEPTH - 1);
    check("a_done_cnt", done_cnt, 1);

    // Falling trigger at 0x100, no post samples, with a valid gap
    do_arm(12'h100, 1'b0, 10'd0);
    send(12'h200, 1'b1);
    send(12'h150, 1'b1);
    tick();
    check("b_gap_armed", bus.state, 1);
    send(12'h050, 1'b1);
    check("b_state_post", bus.state, 2);
    wait_done("b_done_seen");
    check("b_state_done", bus.state, 3);
    check("b_start", bus.start_addr, m_wr);
    rd_check("b_rd_last", DEPTH - 1);
    check("b_rd_value", bus.rd_data, 12'h050);

    // Long pre-trigger ramp wraps the write pointer
    do_arm(12'hFFF, 1'b1, 10'd2);
    for (int k = 0; k < 1100; k++) send(DW'(k), 1'b1);
    check("c_ramp_armed", bus.state, 1);
    send(12'hFFF, 1'b1);
    check("c_state_post", bus.state, 2);
    send(12'h111, 1'b1);
    send(12'h222, 1'b1);
    check("c_done_pulse", bus.capture_done, 1);
    check("c_start", bus.start_addr, m_wr);
    rd_check("c_rd_oldest", 0);
    check("c_rd_oldest_val", bus.rd_data, 79);
    rd_check("c_rd_last", DEPTH - 1);
    check("c_done_cnt", done_cnt, 3);

    // Re-arm coinciding with the final POST sample
    do_arm(12'h800, 1'b1, 10'd1);
    send(12'h100, 1'b1);
    send(12'h900, 1'b1);
    check("d_state_post", bus.state, 2);
    bus.arm = 1'b1;
    send(12'hA00, 1'b0);
    bus.arm = 1'b0;
    check("d_state_armed", bus.state, 1);
    check("d_busy", bus.busy, 1);
    check("d_no_done", bus.capture_done, 0);
    tick(); tick(); tick();
    check("d_done_cnt", done_cnt, 3);

    // Reset in the middle of POST
    send(12'h100, 1'b1);
    send(12'h900, 1'b1);
    check("e_state_post", bus.state, 2);
    rst_n = 1'b0;
    #1;
    check("e_state_idle", bus.state, 0);
    check("e_busy", bus.busy, 0);
    check("e_done", bus.capture_done, 0);
    tick();
    rst_n = 1'b1;
    m_wr  = 0;
    tick(); tick(); tick(); tick();
    check("e_start", bus.start_addr, 0);
    check("e_done_cnt", done_cnt, 3);

`ifdef OSCI_FORCE_TRIG_EN
    // Flat input below level, trigger forced
    do_arm(12'h800, 1'b1, 10'd1);
    send(12'h400, 1'b1);
    send(12'h400, 1'b1);
    check("f_flat_armed", bus.state, 1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    send(12'h400, 1'b1);
    check("f_state_post", bus.state, 2);
    send(12'h400, 1'b1);
    check("f_done_pulse", bus.capture_done, 1);
    check("f_start", bus.start_addr, m_wr);
    tick();
    check("f_done_cnt", done_cnt, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
